// File: rtl/csr_reg_pkg.sv
// Shared CSR address map, mstatus field layout and decode/legalisation helpers
// used by the CSR file and the interrupt arbiter.
package csr_reg_pkg;

    localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_ADDR_MIE      = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_ADDR_CYCLEH   = 12'hC80;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // MPP is hard-wired to machine mode; only MIE and MPIE are storage.
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_WMASK = (32'h0000_0001 << MSTATUS_MIE_BIT) |
                                            (32'h0000_0001 << MSTATUS_MPIE_BIT);
    localparam logic [31:0] MSTATUS_RST   = MSTATUS_FIXED;
    localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [3:0] {
        CSR_NONE     = 4'd0,
        CSR_MSTATUS  = 4'd1,
        CSR_MIE      = 4'd2,
        CSR_MTVEC    = 4'd3,
        CSR_MSCRATCH = 4'd4,
        CSR_MEPC     = 4'd5,
        CSR_MCAUSE   = 4'd6,
        CSR_MCYCLE   = 4'd7,
        CSR_MCYCLEH  = 4'd8,
        CSR_CYCLE    = 4'd9,
        CSR_CYCLEH   = 4'd10
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input logic [31:0] addr);
        csr_sel_e sel;
        sel = CSR_NONE;
        if (addr[31:12] == 20'h0_0000) begin
            case (addr[11:0])
                CSR_ADDR_MSTATUS:  sel = CSR_MSTATUS;
                CSR_ADDR_MIE:      sel = CSR_MIE;
                CSR_ADDR_MTVEC:    sel = CSR_MTVEC;
                CSR_ADDR_MSCRATCH: sel = CSR_MSCRATCH;
                CSR_ADDR_MEPC:     sel = CSR_MEPC;
                CSR_ADDR_MCAUSE:   sel = CSR_MCAUSE;
                CSR_ADDR_MCYCLE:   sel = CSR_MCYCLE;
                CSR_ADDR_MCYCLEH:  sel = CSR_MCYCLEH;
                CSR_ADDR_CYCLE:    sel = CSR_CYCLE;
                CSR_ADDR_CYCLEH:   sel = CSR_CYCLEH;
                default:           sel = CSR_NONE;
            endcase
        end else begin
            sel = CSR_NONE;
        end
        return sel;
    endfunction

    function automatic logic csr_writable(input csr_sel_e sel);
        logic ok;
        case (sel)
            CSR_NONE, CSR_CYCLE, CSR_CYCLEH: ok = 1'b0;
            default:                         ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Value that would actually be stored for a write of data to sel.
    function automatic logic [31:0] csr_legalize(input csr_sel_e sel, input logic [31:0] data);
        logic [31:0] val;
        case (sel)
            CSR_MSTATUS:         val = (data & MSTATUS_WMASK) | MSTATUS_FIXED;
            CSR_MTVEC, CSR_MEPC: val = data & ALIGN4_MASK;
            default:             val = data;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/csr_cycle_cnt.sv
// 64-bit free-running cycle counter; either half can be loaded, and a load
// cycle suppresses the increment for the whole counter.
module csr_cycle_cnt
    import csr_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lo_load,
    input  logic [31:0] lo_data,
    input  logic        hi_load,
    input  logic [31:0] hi_data,
    output logic [63:0] count
);

    logic [63:0] cnt_r;
    logic [63:0] cnt_nxt_s;

    // Next count: per-half load, else 64-bit increment (carry into high half).
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (lo_load || hi_load) begin
            if (lo_load) begin
                cnt_nxt_s[31:0] = lo_data;
            end else begin
                cnt_nxt_s[31:0] = cnt_r[31:0];
            end
            if (hi_load) begin
                cnt_nxt_s[63:32] = hi_data;
            end else begin
                cnt_nxt_s[63:32] = cnt_r[63:32];
            end
        end else begin
            cnt_nxt_s = cnt_r + 64'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 64'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file with two write/read ports (execute stage and interrupt
// arbiter), bypassed combinational reads and registered direct outputs.
module csr_reg
    import csr_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_we_i,
    input  logic [31:0] ex_waddr_i,
    input  logic [31:0] ex_data_i,
    input  logic [31:0] ex_raddr_i,
    output logic [31:0] ex_data_o,
    input  logic        clint_we_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_data_i,
    input  logic [31:0] clint_raddr_i,
    output logic [31:0] clint_data_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o,
    output logic        global_int_en_o
);

    csr_sel_e ex_wsel_s, clint_wsel_s, ex_rsel_s, clint_rsel_s;
    logic        ex_wen_s, clint_wen_s;
    logic [31:0] ex_wval_s, clint_wval_s;

    logic [31:0] mstatus_r, mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r;
    logic [31:0] mstatus_nxt_s, mie_nxt_s, mtvec_nxt_s, mscratch_nxt_s, mepc_nxt_s, mcause_nxt_s;
    logic [31:0] ex_rval_s, clint_rval_s;

    logic        cyc_lo_load_s, cyc_hi_load_s;
    logic [31:0] cyc_lo_data_s, cyc_hi_data_s;
    logic [63:0] cyc_count_s;

    assign ex_wsel_s    = csr_decode(ex_waddr_i);
    assign clint_wsel_s = csr_decode(clint_waddr_i);
    assign ex_rsel_s    = csr_decode(ex_raddr_i);
    assign clint_rsel_s = csr_decode(clint_raddr_i);

    // A clint write that collides with an ex write to the same CSR is dropped.
    assign ex_wen_s     = ex_we_i && csr_writable(ex_wsel_s);
    assign clint_wen_s  = clint_we_i && csr_writable(clint_wsel_s) &&
                          !(ex_wen_s && (ex_wsel_s == clint_wsel_s));
    assign ex_wval_s    = csr_legalize(ex_wsel_s, ex_data_i);
    assign clint_wval_s = csr_legalize(clint_wsel_s, clint_data_i);

    assign cyc_lo_load_s = (ex_wen_s && (ex_wsel_s == CSR_MCYCLE)) ||
                           (clint_wen_s && (clint_wsel_s == CSR_MCYCLE));
    assign cyc_lo_data_s = (ex_wen_s && (ex_wsel_s == CSR_MCYCLE)) ? ex_data_i : clint_data_i;
    assign cyc_hi_load_s = (ex_wen_s && (ex_wsel_s == CSR_MCYCLEH)) ||
                           (clint_wen_s && (clint_wsel_s == CSR_MCYCLEH));
    assign cyc_hi_data_s = (ex_wen_s && (ex_wsel_s == CSR_MCYCLEH)) ? ex_data_i : clint_data_i;

    csr_cycle_cnt u_cycle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .lo_load (cyc_lo_load_s),
        .lo_data (cyc_lo_data_s),
        .hi_load (cyc_hi_load_s),
        .hi_data (cyc_hi_data_s),
        .count   (cyc_count_s)
    );

    // Next-state for the plain CSRs; ex is applied last so it wins.
    always_comb begin
        mstatus_nxt_s  = mstatus_r;
        mie_nxt_s      = mie_r;
        mtvec_nxt_s    = mtvec_r;
        mscratch_nxt_s = mscratch_r;
        mepc_nxt_s     = mepc_r;
        mcause_nxt_s   = mcause_r;
        case (clint_wen_s ? clint_wsel_s : CSR_NONE)
            CSR_MSTATUS:  mstatus_nxt_s  = clint_wval_s;
            CSR_MIE:      mie_nxt_s      = clint_wval_s;
            CSR_MTVEC:    mtvec_nxt_s    = clint_wval_s;
            CSR_MSCRATCH: mscratch_nxt_s = clint_wval_s;
            CSR_MEPC:     mepc_nxt_s     = clint_wval_s;
            CSR_MCAUSE:   mcause_nxt_s   = clint_wval_s;
            default:      mie_nxt_s      = mie_nxt_s;
        endcase
        case (ex_wen_s ? ex_wsel_s : CSR_NONE)
            CSR_MSTATUS:  mstatus_nxt_s  = ex_wval_s;
            CSR_MIE:      mie_nxt_s      = ex_wval_s;
            CSR_MTVEC:    mtvec_nxt_s    = ex_wval_s;
            CSR_MSCRATCH: mscratch_nxt_s = ex_wval_s;
            CSR_MEPC:     mepc_nxt_s     = ex_wval_s;
            CSR_MCAUSE:   mcause_nxt_s   = ex_wval_s;
            default:      mie_nxt_s      = mie_nxt_s;
        endcase
    end

    // CSR storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_r  <= MSTATUS_RST;
            mie_r      <= 32'h0000_0000;
            mtvec_r    <= 32'h0000_0000;
            mscratch_r <= 32'h0000_0000;
            mepc_r     <= 32'h0000_0000;
            mcause_r   <= 32'h0000_0000;
        end else begin
            mstatus_r  <= mstatus_nxt_s;
            mie_r      <= mie_nxt_s;
            mtvec_r    <= mtvec_nxt_s;
            mscratch_r <= mscratch_nxt_s;
            mepc_r     <= mepc_nxt_s;
            mcause_r   <= mcause_nxt_s;
        end
    end

    // Stored-value read mux for the ex port.
    always_comb begin
        ex_rval_s = 32'h0000_0000;
        case (ex_rsel_s)
            CSR_MSTATUS:             ex_rval_s = mstatus_r;
            CSR_MIE:                 ex_rval_s = mie_r;
            CSR_MTVEC:               ex_rval_s = mtvec_r;
            CSR_MSCRATCH:            ex_rval_s = mscratch_r;
            CSR_MEPC:                ex_rval_s = mepc_r;
            CSR_MCAUSE:              ex_rval_s = mcause_r;
            CSR_MCYCLE, CSR_CYCLE:   ex_rval_s = cyc_count_s[31:0];
            CSR_MCYCLEH, CSR_CYCLEH: ex_rval_s = cyc_count_s[63:32];
            default:                 ex_rval_s = 32'h0000_0000;
        endcase
    end

    // Stored-value read mux for the clint port.
    always_comb begin
        clint_rval_s = 32'h0000_0000;
        case (clint_rsel_s)
            CSR_MSTATUS:             clint_rval_s = mstatus_r;
            CSR_MIE:                 clint_rval_s = mie_r;
            CSR_MTVEC:               clint_rval_s = mtvec_r;
            CSR_MSCRATCH:            clint_rval_s = mscratch_r;
            CSR_MEPC:                clint_rval_s = mepc_r;
            CSR_MCAUSE:              clint_rval_s = mcause_r;
            CSR_MCYCLE, CSR_CYCLE:   clint_rval_s = cyc_count_s[31:0];
            CSR_MCYCLEH, CSR_CYCLEH: clint_rval_s = cyc_count_s[63:32];
            default:                 clint_rval_s = 32'h0000_0000;
        endcase
    end

    // Write bypass on both read ports; a write enable implies a mapped CSR,
    // so select equality is address equality.
    always_comb begin
        ex_data_o    = ex_rval_s;
        clint_data_o = clint_rval_s;
        if (ex_wen_s && (ex_rsel_s == ex_wsel_s)) begin
            ex_data_o = ex_wval_s;
        end else if (clint_wen_s && (ex_rsel_s == clint_wsel_s)) begin
            ex_data_o = clint_wval_s;
        end else begin
            ex_data_o = ex_rval_s;
        end
        if (ex_wen_s && (clint_rsel_s == ex_wsel_s)) begin
            clint_data_o = ex_wval_s;
        end else if (clint_wen_s && (clint_rsel_s == clint_wsel_s)) begin
            clint_data_o = clint_wval_s;
        end else begin
            clint_data_o = clint_rval_s;
        end
    end

    assign csr_mtvec_o     = mtvec_r;
    assign csr_mepc_o      = mepc_r;
    assign csr_mstatus_o   = mstatus_r;
    assign global_int_en_o = mstatus_r[MSTATUS_MIE_BIT];

endmodule

// File: tb/tb_csr_reg.sv
// Scoreboard bench for csr_reg: stimulus pushes expectations from an
// address-keyed behavioural model, a monitor pops and compares each cycle.
module tb_csr_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_we, clint_we;
    logic [31:0] ex_waddr, ex_wdata, ex_raddr, clint_waddr, clint_wdata, clint_raddr;
    logic [31:0] ex_data, clint_data, csr_mtvec, csr_mepc, csr_mstatus;
    logic        global_int_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ex_rd;
        logic [31:0] cl_rd;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        gie;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0]     m_csr [int];
    longint unsigned m_cyc;

    logic [31:0] addr_pool [14] = '{32'h300, 32'h304, 32'h305, 32'h340, 32'h341, 32'h342,
                                    32'hB00, 32'hB80, 32'hC00, 32'hC80, 32'h0,
                                    32'h1234_5305, 32'h301, 32'h1300};

    always #5 clk = ~clk;

    csr_reg dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_we_i         (ex_we),
        .ex_waddr_i      (ex_waddr),
        .ex_data_i       (ex_wdata),
        .ex_raddr_i      (ex_raddr),
        .ex_data_o       (ex_data),
        .clint_we_i      (clint_we),
        .clint_waddr_i   (clint_waddr),
        .clint_data_i    (clint_wdata),
        .clint_raddr_i   (clint_raddr),
        .clint_data_o    (clint_data),
        .csr_mtvec_o     (csr_mtvec),
        .csr_mepc_o      (csr_mepc),
        .csr_mstatus_o   (csr_mstatus),
        .global_int_en_o (global_int_en)
    );

    function automatic bit m_mapped(input logic [31:0] a);
        if (a[31:12] != 20'd0) return 1'b0;
        return (a[11:0] inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB80, 12'hC00, 12'hC80});
    endfunction

    function automatic bit m_writable(input logic [31:0] a);
        return m_mapped(a) && (a[11:0] != 12'hC00) && (a[11:0] != 12'hC80);
    endfunction

    function automatic logic [31:0] m_legal(input logic [31:0] a, input logic [31:0] d);
        case (a[11:0])
            12'h300:          return (d & 32'h0000_0088) | 32'h0000_1800;
            12'h305, 12'h341: return d & 32'hFFFF_FFFC;
            default:          return d;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_mapped(a)) return 32'd0;
        case (a[11:0])
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            default:          return m_csr[int'(a[11:0])];
        endcase
    endfunction

    function automatic logic [31:0] m_port_read(input logic [31:0] ra);
        if (ex_we && m_writable(ex_waddr) && ra == ex_waddr) return m_legal(ex_waddr, ex_wdata);
        if (clint_we && m_writable(clint_waddr) && ra == clint_waddr) return m_legal(clint_waddr, clint_wdata);
        return m_read(ra);
    endfunction

    task automatic m_reset();
        m_csr[32'h300] = 32'h0000_1800;
        m_csr[32'h304] = 32'd0;
        m_csr[32'h305] = 32'd0;
        m_csr[32'h340] = 32'd0;
        m_csr[32'h341] = 32'd0;
        m_csr[32'h342] = 32'd0;
        m_cyc = 64'd0;
    endtask

    task automatic m_commit();
        logic [31:0] wa[$];
        logic [31:0] wd[$];
        bit lo_ld = 1'b0, hi_ld = 1'b0;
        logic [31:0] lo_d = 32'd0, hi_d = 32'd0;
        if (ex_we && m_writable(ex_waddr)) begin
            wa.push_back(ex_waddr); wd.push_back(ex_wdata);
        end
        if (clint_we && m_writable(clint_waddr) && !(ex_we && m_writable(ex_waddr) && ex_waddr == clint_waddr)) begin
            wa.push_back(clint_waddr); wd.push_back(clint_wdata);
        end
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i][11:0] == 12'hB00) begin lo_ld = 1'b1; lo_d = wd[i]; end
            else if (wa[i][11:0] == 12'hB80) begin hi_ld = 1'b1; hi_d = wd[i]; end
            else m_csr[int'(wa[i][11:0])] = m_legal(wa[i], wd[i]);
        end
        if (lo_ld || hi_ld)
            m_cyc = {(hi_ld ? hi_d : m_cyc[63:32]), (lo_ld ? lo_d : m_cyc[31:0])};
        else
            m_cyc = m_cyc + 64'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ewe, input logic [31:0] ewa, input logic [31:0] ed, input logic [31:0] era,
                         input bit cwe, input logic [31:0] cwa, input logic [31:0] cd, input logic [31:0] cra);
        exp_t e;
        @(negedge clk);
        ex_we = ewe; ex_waddr = ewa; ex_wdata = ed; ex_raddr = era;
        clint_we = cwe; clint_waddr = cwa; clint_wdata = cd; clint_raddr = cra;
        e.ex_rd   = m_port_read(era);
        e.cl_rd   = m_port_read(cra);
        e.mstatus = m_csr[32'h300];
        e.mtvec   = m_csr[32'h305];
        e.mepc    = m_csr[32'h341];
        e.gie     = m_csr[32'h300][3];
        sb_q.push_back(e);
    endtask

    task automatic commit();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_commit();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, 32'd0, 32'd0, 32'hC00, 1'b0, 32'd0, 32'd0, 32'h300);
            commit();
        end
    endtask

    // Monitor: read ports are always presenting data, sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ex_rdata", ex_data, e.ex_rd);
                chk("clint_rdata", clint_data, e.cl_rd);
                chk("mstatus_out", csr_mstatus, e.mstatus);
                chk("mtvec_out", csr_mtvec, e.mtvec);
                chk("mepc_out", csr_mepc, e.mepc);
                chk("gie_out", {31'd0, global_int_en}, {31'd0, e.gie});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ex_we = 1'b0; ex_waddr = 32'd0; ex_wdata = 32'd0; ex_raddr = 32'd0;
        clint_we = 1'b0; clint_waddr = 32'd0; clint_wdata = 32'd0; clint_raddr = 32'd0;
        m_reset();

        idle(2);
        drive(1'b0, 32'd0, 32'd0, 32'h300, 1'b0, 32'd0, 32'd0, 32'hC00);
        #3;
        chk("rst_mstatus", csr_mstatus, 32'h0000_1800);
        chk("rst_gie", {31'd0, global_int_en}, 32'd0);
        chk("rst_read_mstatus", ex_data, 32'h0000_1800);
        commit();

        // Release, then ten edges of idle counting.
        drive(1'b0, 32'd0, 32'd0, 32'hC00, 1'b0, 32'd0, 32'd0, 32'h300);
        rst_n = 1'b1;
        commit();
        idle(9);
        drive(1'b0, 32'd0, 32'd0, 32'hC00, 1'b0, 32'd0, 32'd0, 32'hC80);
        #3;
        chk("cycle_after_10", ex_data, 32'd10);
        chk("cycleh_after_10", clint_data, 32'd0);
        commit();

        drive(1'b1, 32'h300, 32'h8, 32'h300, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        chk("mstatus_not_bypassed", csr_mstatus, 32'h0000_1800);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'h300, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        chk("mie_gie", {31'd0, global_int_en}, 32'd1);
        chk("mstatus_1808", csr_mstatus, 32'h0000_1808);
        commit();
        drive(1'b1, 32'h300, 32'hFFFF_FFFF, 32'h300, 1'b0, 32'd0, 32'd0, 32'd0);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'h300, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        chk("mstatus_1888", ex_data, 32'h0000_1888);
        commit();

        drive(1'b1, 32'h341, 32'h100, 32'd0, 1'b1, 32'h341, 32'h200, 32'h341);
        #3;
        chk("bypass_ex_prio", clint_data, 32'h100);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        chk("mepc_ex_wins", csr_mepc, 32'h100);
        commit();
        drive(1'b1, 32'h341, 32'h44, 32'd0, 1'b1, 32'h342, 32'h8000_0004, 32'd0);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'h342, 1'b0, 32'd0, 32'd0, 32'h341);
        #3;
        chk("mcause_both", ex_data, 32'h8000_0004);
        chk("mepc_both", csr_mepc, 32'h44);
        commit();

        repeat (5) begin
            drive(1'b0, 32'd0, 32'd0, addr_pool[$urandom_range(0, 9)], 1'b1, 32'd0, 32'h0000_DEAD, 32'd0);
            commit();
        end
        drive(1'b1, 32'hC00, 32'd0, 32'hC00, 1'b0, 32'd0, 32'd0, 32'h300);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'h1234_5305, 1'b0, 32'd0, 32'd0, 32'hC00);
        #3;
        chk("unmapped_read", ex_data, 32'd0);
        commit();

        drive(1'b1, 32'hB00, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'hB80, 32'h5, 32'd0);
        commit();
        idle(2);
        drive(1'b0, 32'd0, 32'd0, 32'hC80, 1'b0, 32'd0, 32'd0, 32'hC00);
        #3;
        chk("cycleh_carry", ex_data, 32'd6);
        chk("cycle_wrap", clint_data, 32'd1);
        commit();
        drive(1'b1, 32'h305, 32'h1003, 32'h305, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        chk("mtvec_bypass_align", ex_data, 32'h1000);
        commit();

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1), addr_pool[$urandom_range(0, 13)], $urandom,
                  addr_pool[$urandom_range(0, 13)],
                  $urandom_range(0, 1), addr_pool[$urandom_range(0, 13)], $urandom,
                  addr_pool[$urandom_range(0, 13)]);
            commit();
        end

        drive(1'b1, 32'h305, 32'h1000, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        commit();
        drive(1'b1, 32'h305, 32'h80, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mtvec_async_rst", csr_mtvec, 32'd0);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'h305, 1'b0, 32'd0, 32'd0, 32'hC00);
        #3;
        chk("mtvec_in_rst", csr_mtvec, 32'd0);
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'hC00, 1'b0, 32'd0, 32'd0, 32'h305);
        rst_n = 1'b1;
        commit();
        drive(1'b0, 32'd0, 32'd0, 32'hC00, 1'b0, 32'd0, 32'd0, 32'h305);
        #3;
        chk("mtvec_after_rel", csr_mtvec, 32'd0);
        chk("cycle_after_rel", ex_data, 32'd1);
        commit();

        idle(2);
        @(negedge clk);
        #3;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
